// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its wait timer.
package data_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/wait_timer.sv
// Loadable down-counter that flags the last wait-state cycle of an access.
module wait_timer
  import data_mem_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A zero load expires at once so the FSM can skip WAIT entirely.
  assign expire = (count == CNT_W'(1)) || (load && (load_value == '0));

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a request/response handshake with fixed wait states.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_busy
);

  localparam int               DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  state_e state, state_next;

  logic                  accept;
  logic                  expire;
  logic                  enter_resp;
  logic                  lat_write;
  logic [ADDR_W-1:0]     lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic                  acc_write;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [DATA_W-1:0]     mem [DEPTH];

  assign accept = req_valid && req_ready;

  wait_timer u_wait_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .load_value (WAIT_LOAD),
    .expire     (expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept)    state_next = expire ? ST_RESP : ST_WAIT;
      ST_WAIT: if (expire)    state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_busy  = 1'b1;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        mem_busy  = 1'b0;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // With zero wait states the array is accessed on the accept edge, before the latch holds the request.
  assign enter_resp = (state != ST_RESP) && (state_next == ST_RESP);
  assign acc_write  = (state == ST_IDLE) ? req_write : lat_write;
  assign acc_addr   = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata  = (state == ST_IDLE) ? req_wdata : lat_wdata;
  assign acc_err    = |acc_addr[ADDR_W-1:DEPTH_LOG2];
  assign acc_idx    = acc_addr[DEPTH_LOG2-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= acc_write ? acc_wdata : (acc_err ? ERR_RDATA : mem[acc_idx]);
      end
    end
  end

  // NOTE: the array has no reset; clearing it would force flops instead of RAM and is not wanted.
  always_ff @(posedge clock) begin
    if (enter_resp && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
